// File: rtl/usb_rx_data_buffer_pkg.sv
// Shared types and constants for the USB receive data buffer.
package usb_buf_pkg;

  localparam int BUF_DEPTH = 64;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} rx_size_t;

  // The reserved size code reads a full word, the same as SIZE_WORD.
  function automatic logic [2:0] size_to_bytes(rx_size_t size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_data_buffer_if.sv
// Bus between the receiver/slave/controller side and the receive buffer.
// Error flag signals exist only when RX_BUF_ERR_EN is defined.
interface usb_rx_data_buffer_if
  import usb_buf_pkg::*;
#(
  parameter int OCC_W = 7
) ();

  logic             store_rx_packet_data;
  logic [7:0]       rx_packet_data;
  logic             get_rx_data;
  rx_size_t         rx_data_size;
  logic             flush;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [31:0]      rx_data;
`ifdef RX_BUF_ERR_EN
  logic             rx_overrun;
  logic             rx_underrun;

  modport master (
    output store_rx_packet_data, rx_packet_data, get_rx_data, rx_data_size, flush,
    input  buffer_occupancy, rx_data, rx_overrun, rx_underrun
  );
  modport slave (
    input  store_rx_packet_data, rx_packet_data, get_rx_data, rx_data_size, flush,
    output buffer_occupancy, rx_data, rx_overrun, rx_underrun
  );
`else
  modport master (
    output store_rx_packet_data, rx_packet_data, get_rx_data, rx_data_size, flush,
    input  buffer_occupancy, rx_data
  );
  modport slave (
    input  store_rx_packet_data, rx_packet_data, get_rx_data, rx_data_size, flush,
    output buffer_occupancy, rx_data
  );
`endif

endinterface

// File: rtl/usb_rx_data_buffer_mem.sv
// Byte storage for the receive buffer: one write port and four combinational
// read ports at consecutive addresses, wrapping modulo DEPTH.
module rx_buf_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [7:0]         wdata,
  input  logic [AW-1:0]      raddr,
  output logic [3:0][7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Address arithmetic is AW bits wide, so a read straddling the top wraps to 0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_port
    assign rdata[gi] = mem[raddr + AW'(gi)];
  end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Circular receive FIFO returning 1/2/4 little-endian bytes per get.
// Optional sticky overrun/underrun flags are built when RX_BUF_ERR_EN is defined.
module usb_rx_data_buffer
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_rx_data_buffer_if.slave  bus
);

  localparam int AW = OCC_W - 1;

  logic [OCC_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [OCC_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ;
  logic [2:0]       n_req;
  logic [2:0]       n_pop;
  logic             full;
  logic             wr_accept;
  logic [3:0][7:0]  rd_bytes;
  logic [3:0][7:0]  rd_lanes;
  logic [31:0]      rx_data_reg, rx_data_next;

  assign occ   = wr_ptr_reg - rd_ptr_reg;
  assign full  = (occ == OCC_W'(DEPTH));
  assign n_req = size_to_bytes(bus.rx_data_size);

  always_comb begin
    n_pop = 3'd0;
    if (bus.get_rx_data) begin
      n_pop = (OCC_W'(n_req) <= occ) ? n_req : occ[2:0];
    end
  end

  // A full FIFO still takes a byte when the same-cycle get frees a slot.
  assign wr_accept = bus.store_rx_packet_data && (!full || (n_pop != 3'd0));

  rx_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept && !bus.flush),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (bus.rx_packet_data),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (rd_bytes)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lanes[gi] = (3'(gi) < n_pop) ? rd_bytes[gi] : 8'h00;
  end

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    rx_data_next = rx_data_reg;
    if (bus.flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      rx_data_next = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_next = wr_ptr_reg + OCC_W'(1);
      end
      if (bus.get_rx_data) begin
        rd_ptr_next  = rd_ptr_reg + OCC_W'(n_pop);
        rx_data_next = rd_lanes;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rx_data_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      rx_data_reg <= rx_data_next;
    end
  end

  assign bus.buffer_occupancy = occ;
  assign bus.rx_data          = rx_data_reg;

`ifdef RX_BUF_ERR_EN
  logic overrun_reg, overrun_next;
  logic underrun_reg, underrun_next;

  // Flush clears the flags and masks any error raised in the same cycle.
  always_comb begin
    overrun_next  = overrun_reg  | (bus.store_rx_packet_data && !wr_accept);
    underrun_next = underrun_reg | (bus.get_rx_data && (n_pop < n_req));
    if (bus.flush) begin
      overrun_next  = 1'b0;
      underrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      overrun_reg  <= overrun_next;
      underrun_reg <= underrun_next;
    end
  end

  assign bus.rx_overrun  = overrun_reg;
  assign bus.rx_underrun = underrun_reg;
`endif

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Scoreboard bench for usb_rx_data_buffer: a queue-based byte FIFO model feeds
// expected outputs to a monitor that compares once per cycle.
module tb_usb_rx_data_buffer;
  import usb_buf_pkg::*;

  localparam int DEPTH = BUF_DEPTH;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic tb_clk = 1'b0;
  logic n_rst;
  always #5 tb_clk = ~tb_clk;

  usb_rx_data_buffer_if #(.OCC_W(OCC_W)) bus ();

  usb_rx_data_buffer #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rx;
    int          occ;
    bit          ovr;
    bit          und;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  model_q[$];
  logic [31:0] m_rx;
  bit          m_ovr, m_und;
  bit          verbose;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        mon_e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is applied with pre-edge occupancy.
  task automatic step(bit st, logic [7:0] d, bit g, logic [1:0] sz, bit fl);
    int occ, nreq, npop;
    @(negedge tb_clk);
    #1;
    bus.store_rx_packet_data = st;
    bus.rx_packet_data       = d;
    bus.get_rx_data          = g;
    bus.rx_data_size         = rx_size_t'(sz);
    bus.flush                = fl;
    if (fl) begin
      model_q.delete();
      m_rx  = '0;
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      occ  = model_q.size();
      nreq = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      npop = 0;
      if (g) begin
        npop = (nreq < occ) ? nreq : occ;
        m_rx = '0;
        for (int k = 0; k < npop; k++) m_rx[8*k +: 8] = model_q.pop_front();
        if (npop < nreq) m_und = 1'b1;
      end
      if (st) begin
        if (occ < DEPTH || npop > 0) model_q.push_back(d);
        else m_ovr = 1'b1;
      end
    end
    sb_q.push_back('{m_rx, model_q.size(), m_ovr, m_und});
    if (verbose)
      $display("txn st=%0b d=%02h get=%0b sz=%0d flush=%0b -> exp rx=%08h occ=%0d",
               st, d, g, sz, fl, m_rx, model_q.size());
  endtask

  task automatic idle();
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.rx_data_size         = SIZE_BYTE;
    bus.flush                = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rx_data"}, bus.rx_data, 32'h0);
    check({tag, "_occupancy"}, 32'(bus.buffer_occupancy), 32'h0);
`ifdef RX_BUF_ERR_EN
    check({tag, "_overrun"}, 32'(bus.rx_overrun), 32'h0);
    check({tag, "_underrun"}, 32'(bus.rx_underrun), 32'h0);
`endif
  endtask

  task automatic model_reset();
    model_q.delete();
    m_rx  = '0;
    m_ovr = 1'b0;
    m_und = 1'b0;
  endtask

  // Monitor: every cycle with an outstanding stimulus record is compared.
  always @(negedge tb_clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("rx_data", bus.rx_data, mon_e.rx);
      check("occupancy", 32'(bus.buffer_occupancy), 32'(mon_e.occ));
`ifdef RX_BUF_ERR_EN
      check("overrun", 32'(bus.rx_overrun), 32'(mon_e.ovr));
      check("underrun", 32'(bus.rx_underrun), 32'(mon_e.und));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    verbose = 1'b1;
    idle();
    model_reset();
    n_rst = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge tb_clk);
    #1 n_rst = 1'b1;

    // Single byte
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    // Word read
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0);
    step(0, 8'h00, 1, 2, 0);

    // Fill, overflow, drain
    verbose = 1'b0;
    for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 0, 0);
    verbose = 1'b1;
    step(1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 2, 0);

    // Wrap across index 63 -> 0 from a known pointer origin
    step(0, 8'h00, 0, 0, 1);
    verbose = 1'b0;
    for (int i = 0; i < 62; i++) step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 62; i++) step(0, 8'h00, 1, 0, 0);
    verbose = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 2, 0);

    // Short read then empty read
    step(1, 8'h5A, 0, 0, 0);
    step(1, 8'h6B, 0, 0, 0);
    step(0, 8'h00, 1, 2, 0);
    step(0, 8'h00, 1, 3, 0);

    // Full with simultaneous store+get, then flush beating store+get
    verbose = 1'b0;
    for (int i = 0; i < 64; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    verbose = 1'b1;
    step(1, 8'hC7, 1, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    step(1, 8'hD1, 1, 1, 1);
    step(0, 8'h00, 0, 0, 0);

    // Randomised traffic with occasional flushes
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 35),
           2'($urandom_range(0, 3)), ($urandom_range(0, 199) == 0));
    end

    // Reset asserted mid-stream
    verbose = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 1, 0, 0);
    @(negedge tb_clk);
    #2;
    idle();
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge tb_clk);
    @(negedge tb_clk);
    #1 n_rst = 1'b1;
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0);

    @(negedge tb_clk);
    @(negedge tb_clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_rx_data_buffer.md
Name: usb_rx_data_buffer

Overview:
Downstream consumer of the USB receiver. Captures each byte the receiver presents with its store strobe into a 64-byte circular FIFO. Returns 1, 2 or 4 bytes per request to the AHB-Lite slave side, little-endian. Reports occupancy to the protocol controller, and can be flushed by it.

Parameters:
DEPTH, 64, FIFO capacity in bytes; must be a power of two, 4 or more.
OCC_W, 7, width of occupancy; equals clog2(DEPTH)+1.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
store_rx_packet_data  in  1  one-cycle strobe from the receiver: write rx_packet_data
rx_packet_data  in  8  byte from the receiver
get_rx_data  in  1  one-cycle read request from the slave side
rx_data_size  in  2  read size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes
flush  in  1  one-cycle strobe: empty the FIFO
buffer_occupancy  out  OCC_W  number of bytes held, range 0..DEPTH
rx_data  out  32  registered read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on n_rst.
- Reset values: pointers = 0, buffer_occupancy = 0, rx_data = 0, error flags (when compiled in) = 0. Memory contents are don't-care.
- Storage: DEPTH x 8 array.
  - wr_ptr and rd_ptr are OCC_W bits wide; the low bits index the array and the MSB is the wrap bit.
  - buffer_occupancy = wr_ptr - rd_ptr, taken from the registered pointers. It therefore reflects an event on the cycle after that event.
- Write: on a store strobe, rx_packet_data goes to mem[wr_ptr] and wr_ptr increments.
  - Accepted when occupancy < DEPTH.
  - Also accepted when the FIFO is full and a get in the same cycle pops at least 1 byte.
  - Otherwise the byte is dropped and the pointers are unchanged.
- Read:
  - n_req = 1/2/4 per rx_data_size; n_pop = min(n_req, occupancy before the edge).
  - On the next edge, rx_data byte k (k < n_pop) = mem[rd_ptr+k], with wrap-around handled. Byte 0 sits in bits [7:0].
  - Bytes from n_pop up to 3 are driven to 0. rd_ptr advances by n_pop.
  - Latency is 1 cycle: rx_data is valid the cycle after the get and holds until the next get or flush.
  - A get on an empty FIFO gives rx_data = 0 and leaves rd_ptr unchanged.
- Simultaneous store + get:
  - Both take effect in the same cycle.
  - The read uses the pre-edge occupancy, so the byte being stored is never returned in that cycle.
  - Net occupancy change = +1 (if accepted) - n_pop.
- Flush:
  - Highest priority: in the flush cycle any store or get is ignored.
  - wr_ptr and rd_ptr are set to 0 and rx_data is set to 0.
  - Occupancy reads 0 on the next cycle.
- Wrap-around: the pointers wrap naturally at 2*DEPTH. A multi-byte read that straddles index DEPTH-1 to 0 must return bytes in FIFO order.
- Reset mid-operation: immediate return to reset values. No partial read or write survives.
- No stalls: the block always accepts strobes and holds no combinational path from inputs to outputs.

Optional Feature:
Macro RX_BUF_ERR_EN.
- Defined: adds two outputs, rx_overrun and rx_underrun, 1 bit each.
  - rx_overrun is a sticky flag set when a store is dropped.
  - rx_underrun is a sticky flag set when a get has n_pop < n_req.
  - Both flags clear on flush or reset.
  - A flush in the same cycle as an error event wins, so the flag stays 0.
- Undefined: the ports do not exist, and dropped and short operations are silent.
- All other behaviour is identical in both builds.

Decomposition:
- Package usb_buf_pkg holds:
  - localparam BUF_DEPTH = 64;
  - typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} rx_size_t;
  - a function size_to_bytes(rx_size_t) returning 3 bits.
- One sub-module, rx_buf_mem: the register-array storage with one write port and four combinational read ports at rd_ptr+0..3 (mod DEPTH).
- Pointer logic, occupancy and output registers stay in the top module.

Test Plan:
- Reset, then store 0xA5 then get size 0 -> occupancy 1 after the store, then 0; rx_data = 0x000000A5.
- Store 0x11, 0x22, 0x33, 0x44, then get size 2 -> rx_data = 0x44332211; occupancy goes 4 -> 0.
- Store 64 bytes 0x00..0x3F, then a 65th byte 0xFF -> occupancy stays 64 and the 0xFF is dropped (rx_overrun = 1 when RX_BUF_ERR_EN is defined). Sixteen size-2 gets then return 0x03020100 through 0x3F3E3D3C.
- Wrap test:
  - store 62 bytes, get 62 bytes as single-byte reads, then store 0xB0..0xB3;
  - get size 2 -> rx_data = 0xB3B2B1B0 across the index 63 -> 0 boundary.
- Store 2 bytes 0x5A, 0x6B, then get size 2 -> rx_data = 0x00006B5A; occupancy 0 (rx_underrun = 1 when enabled). A further get -> rx_data = 0.
- Fill to 64:
  - a store of 0xC7 with a simultaneous get size 0 -> byte accepted, occupancy stays 64;
  - then flush with a simultaneous store and get -> occupancy 0, rx_data 0, flags 0;
  - n_rst asserted mid-stream -> all outputs 0 at once.
